// File: rtl/controller_sysinfo_pkg.sv
// controller_sysinfo_pkg
// Shared definitions for the system-information slave: bus widths, the word
// address map, CTRL bit positions and the CAPS word layout.
package controller_sysinfo_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  // Word address map
  localparam logic [ADDR_W-1:0] ADDR_SYSTEM_ID = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH   = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_CAPS      = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_RESERVED  = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_USER_BASE = 4'd8;

  // CTRL register bits
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // CAPS layout: [15:8] PRESCALE-1 (low byte), [3:0] NUM_USER, rest zero
  localparam int CAPS_NUM_USER_LSB = 0;
  localparam int CAPS_PRESCALE_LSB = 8;

  function automatic logic [DATA_W-1:0] caps_word(input int prescale, input int num_user);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CAPS_PRESCALE_LSB +: 8] = 8'(prescale - 1);
    w[CAPS_NUM_USER_LSB +: 4] = 4'(num_user);
    return w;
  endfunction

endpackage

// File: rtl/controller_sysinfo_if.sv
// controller_sysinfo_if
// Avalon-MM style slave bus for the system-information block.
//   address       word address
//   read/write    single-cycle strobes
//   writedata     write data
//   readdata      registered read data (slave output)
//   readdatavalid one-cycle pulse, one clock after read (slave output)
interface controller_sysinfo_if;
  import controller_sysinfo_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/controller_sysinfo_uptime.sv
// controller_sysinfo_uptime
// Prescaled free-running 64-bit uptime counter with a high-word snapshot.
//   clock, reset_n  clock and asynchronous active-low reset
//   en              prescaler and counter advance only while high
//   clr             zeroes prescaler, counter and snapshot (beats increment)
//   snap            latch counter[63:32] into the snapshot this cycle
//   count_lo        counter[31:0], value before this cycle's increment
//   snapshot        last latched high word
module controller_sysinfo_uptime #(
  parameter int PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] snapshot
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   count_q, count_d;
  logic [31:0]   snap_q, snap_d;

  // The snapshot takes the pre-increment high word so it pairs with the
  // low word returned by the same read; clear is applied last so it wins.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    snap_d  = snap_q;
    if (snap) begin
      snap_d = count_q[63:32];
    end
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = count_q + 64'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (clr) begin
      presc_d = '0;
      count_d = '0;
      snap_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
      snap_q  <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      snap_q  <= snap_d;
    end
  end

  assign count_lo = count_q[31:0];
  assign snapshot = snap_q;

endmodule

// File: rtl/controller_sysinfo.sv
// controller_sysinfo
// System identification / build information slave. Returns SYSTEM_ID and
// TIMESTAMP, a prescaled 64-bit uptime counter with tear-free high word,
// a scratch register, a control word, a capabilities word and user constants.
//   clock, reset_n  clock and asynchronous active-low reset
//   bus             slave side of controller_sysinfo_if (1-cycle read latency)
module controller_sysinfo
  import controller_sysinfo_pkg::*;
#(
  parameter logic [31:0]  SYSTEM_ID  = 32'h0000C001,
  parameter logic [31:0]  TIMESTAMP  = 32'd1532492830,
  parameter int           PRESCALE   = 1,
  parameter int           NUM_USER   = 4,
  parameter logic [255:0] USER_WORDS = '0,
  parameter logic         CTRL_RESET = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  controller_sysinfo_if.slave bus
);

  localparam logic [DATA_W-1:0] CAPS       = caps_word(PRESCALE, NUM_USER);
  localparam logic [3:0]        NUM_USER_W = 4'(NUM_USER);

  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rvalid_q, rvalid_d;

  logic              wr_scratch, wr_ctrl, clr, snap;
  logic [31:0]       uptime_lo, snapshot;
  logic [DATA_W-1:0] rdata_mux;
  logic [2:0]        user_idx;
  logic [7:0]        user_lsb;

  assign wr_scratch = bus.write && (bus.address == ADDR_SCRATCH);
  assign wr_ctrl    = bus.write && (bus.address == ADDR_CTRL);
  assign clr        = wr_ctrl && bus.writedata[CTRL_CLR_BIT];
  assign snap       = bus.read && (bus.address == ADDR_UPTIME_LO);
  assign user_idx   = bus.address[2:0];
  assign user_lsb   = {user_idx, 5'd0};

  controller_sysinfo_uptime #(
    .PRESCALE(PRESCALE)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en_q),
    .clr      (clr),
    .snap     (snap),
    .count_lo (uptime_lo),
    .snapshot (snapshot)
  );

  // Read mux works from current register state, so a simultaneous write is
  // not visible until the following read. Addresses 8..15 fall to default.
  always_comb begin
    rdata_mux = '0;
    case (bus.address)
      ADDR_SYSTEM_ID: rdata_mux = SYSTEM_ID;
      ADDR_TIMESTAMP: rdata_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rdata_mux = uptime_lo;
      ADDR_UPTIME_HI: rdata_mux = snapshot;
      ADDR_SCRATCH:   rdata_mux = scratch_q;
      ADDR_CTRL:      rdata_mux[CTRL_EN_BIT] = en_q;
      ADDR_CAPS:      rdata_mux = CAPS;
      ADDR_RESERVED:  rdata_mux = '0;
      default: begin
        if ((bus.address >= ADDR_USER_BASE) && ({1'b0, user_idx} < NUM_USER_W)) begin
          rdata_mux = USER_WORDS[user_lsb +: 32];
        end
      end
    endcase
  end

  // readdata holds its last value when no read is issued.
  always_comb begin
    scratch_d  = scratch_q;
    en_d       = en_q;
    readdata_d = readdata_q;
    rvalid_d   = bus.read;
    if (wr_scratch) begin
      scratch_d = bus.writedata;
    end
    if (wr_ctrl) begin
      en_d = bus.writedata[CTRL_EN_BIT];
    end
    if (bus.read) begin
      readdata_d = rdata_mux;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      en_q       <= CTRL_RESET;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      en_q       <= en_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_controller_sysinfo.sv
// tb_controller_sysinfo
// Directed self-checking bench for controller_sysinfo with PRESCALE=4,
// NUM_USER=4 and a nonzero fifth user word that must stay hidden.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a period away from the active rising edge.
module tb_controller_sysinfo;
  import controller_sysinfo_pkg::*;

  localparam logic [255:0] USER_INIT = {32'h0, 32'h0, 32'h0, 32'h55555555,
                                        32'h44444444, 32'h33333333,
                                        32'h22222222, 32'h11111111};

  logic clock;
  logic reset_n;
  int   check_count;
  int   error_count;

  controller_sysinfo_if bus();

  controller_sysinfo #(
    .SYSTEM_ID  (32'h0000C001),
    .TIMESTAMP  (32'd1532492830),
    .PRESCALE   (4),
    .NUM_USER   (4),
    .USER_WORDS (USER_INIT),
    .CTRL_RESET (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle from a falling edge; returns on the next falling edge
  // with strobes released.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [3:0] addr, input logic [31:0] wdata);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = addr;
    bus.writedata = wdata;
    @(negedge clock);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic writeWord(input logic [3:0] addr, input logic [31:0] wdata);
    applyStimulus(1'b0, 1'b1, addr, wdata);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput({tag, "_valid"}, bus.readdatavalid, 1'b1);
    checkOutput(tag, bus.readdata, expected);
  endtask

  initial begin
    check_count   = 0;
    error_count   = 0;
    reset_n       = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;

    repeat (3) @(negedge clock);
    checkOutput("reset_readdata", bus.readdata, 32'h0);
    checkOutput("reset_rvalid", bus.readdatavalid, 1'b0);
    reset_n = 1'b1;

    $display("[TB] identity words after reset");
    readCheck("sysid", ADDR_SYSTEM_ID, 32'h0000C001);
    readCheck("timestamp", ADDR_TIMESTAMP, 32'd1532492830);
    readCheck("caps", ADDR_CAPS, 32'h00000304);
    @(negedge clock);
    checkOutput("rvalid_one_cycle", bus.readdatavalid, 1'b0);
    checkOutput("readdata_hold", bus.readdata, 32'h00000304);
    readCheck("ctrl_reset", ADDR_CTRL, 32'h1);
    readCheck("snap_reset", ADDR_UPTIME_HI, 32'h0);
    readCheck("scratch_reset", ADDR_SCRATCH, 32'h0);

    $display("[TB] scratch, read-only words and user constants");
    writeWord(ADDR_SCRATCH, 32'hDEADBEEF);
    readCheck("scratch_rw", ADDR_SCRATCH, 32'hDEADBEEF);
    writeWord(ADDR_SYSTEM_ID, 32'h12345678);
    readCheck("sysid_ro", ADDR_SYSTEM_ID, 32'h0000C001);
    writeWord(ADDR_CAPS, 32'hFFFFFFFF);
    readCheck("caps_ro", ADDR_CAPS, 32'h00000304);
    readCheck("user0", 4'd8, 32'h11111111);
    readCheck("user3", 4'd11, 32'h44444444);
    readCheck("user4_hidden", 4'd12, 32'h0);
    readCheck("user7_hidden", 4'd15, 32'h0);
    readCheck("reserved", ADDR_RESERVED, 32'h0);
    applyStimulus(1'b1, 1'b1, ADDR_SCRATCH, 32'hCAFEF00D);
    checkOutput("rw_same_old", bus.readdata, 32'hDEADBEEF);
    readCheck("rw_same_new", ADDR_SCRATCH, 32'hCAFEF00D);
    writeWord(ADDR_CTRL, 32'hFFFFFFFD);
    readCheck("ctrl_mask", ADDR_CTRL, 32'h1);

    $display("[TB] uptime counting and freeze");
    // Clear edge is P0; after edge Pk the count is k/4. The read issued after
    // 40 further edges samples at P41 and returns the post-P40 value 10.
    writeWord(ADDR_CTRL, 32'h3);
    repeat (40) @(negedge clock);
    readCheck("uptime_40", ADDR_UPTIME_LO, 32'd10);
    readCheck("uptime_hi_40", ADDR_UPTIME_HI, 32'h0);
    // Disable lands at P43 (still enabled there): 43/4 = 10, frozen after.
    writeWord(ADDR_CTRL, 32'h0);
    repeat (20) @(negedge clock);
    readCheck("uptime_frozen", ADDR_UPTIME_LO, 32'd10);
    readCheck("ctrl_off", ADDR_CTRL, 32'h0);

    $display("[TB] low-word wrap and snapshot");
    writeWord(ADDR_CTRL, 32'h2);
    force dut.u_uptime.count_d = 64'h0000_0000_FFFF_FFFF;
    @(negedge clock);
    release dut.u_uptime.count_d;
    readCheck("preload_lo", ADDR_UPTIME_LO, 32'hFFFFFFFF);
    // Enable edge E0, prescaler 1..3 at E1..E3, increment at E4.
    writeWord(ADDR_CTRL, 32'h1);
    repeat (4) @(negedge clock);
    readCheck("wrap_lo", ADDR_UPTIME_LO, 32'h0);
    readCheck("wrap_hi", ADDR_UPTIME_HI, 32'h1);
    repeat (20) @(negedge clock);
    readCheck("snap_hold", ADDR_UPTIME_HI, 32'h1);

    $display("[TB] clear against terminal count");
    writeWord(ADDR_CTRL, 32'h2);
    readCheck("snap_cleared", ADDR_UPTIME_HI, 32'h0);
    writeWord(ADDR_CTRL, 32'h1);
    repeat (3) @(negedge clock);
    writeWord(ADDR_CTRL, 32'h3);
    readCheck("clr_wins_lo", ADDR_UPTIME_LO, 32'h0);
    readCheck("clr_wins_hi", ADDR_UPTIME_HI, 32'h0);
    readCheck("clr_wins_ctrl", ADDR_CTRL, 32'h1);

    $display("[TB] reset during read burst");
    writeWord(ADDR_SCRATCH, 32'h12345678);
    writeWord(ADDR_CTRL, 32'h0);
    bus.read    = 1'b1;
    bus.address = ADDR_SCRATCH;
    @(negedge clock);
    checkOutput("burst_valid", bus.readdatavalid, 1'b1);
    checkOutput("burst_data", bus.readdata, 32'h12345678);
    bus.address = ADDR_SYSTEM_ID;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_rvalid_drop", bus.readdatavalid, 1'b0);
    checkOutput("rst_readdata", bus.readdata, 32'h0);
    bus.read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("rst_read_dropped", bus.readdatavalid, 1'b0);
    readCheck("rst_scratch", ADDR_SCRATCH, 32'h0);
    readCheck("rst_ctrl", ADDR_CTRL, 32'h1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
